// File: rtl/adc_sample_decimator_if.sv
// Capture-side bus of the ADC decimator: raw sample inputs, window control and the
// packed result handshake. slave = decimator, master = producer/consumer side.
interface adc_sample_decimator_if #(
  parameter int ADC_WIDTH = 14,
  parameter int DEC_WIDTH = 16,
  parameter int OUT_WIDTH = 16
);
  logic [ADC_WIDTH-1:0]   adc_dat_a_i;
  logic [ADC_WIDTH-1:0]   adc_dat_b_i;
  logic                   adc_valid_i;
  logic                   enable_i;
  logic [DEC_WIDTH-1:0]   dec_factor_i;
  logic [3:0]             avg_shift_i;
  logic                   sample_ack_i;
  logic                   ovr_clr_i;
  logic [2*OUT_WIDTH-1:0] sample_o;
  logic                   sample_valid_o;
  logic [15:0]            overrun_cnt_o;
  logic                   busy_o;
  logic                   dbg_state_o;

  // sample_valid_o/sample_ack_i: the result is held and valid stays high until a
  // cycle with ack high; ack while valid is low has no effect.
  modport slave (
    input  adc_dat_a_i, adc_dat_b_i, adc_valid_i, enable_i, dec_factor_i,
           avg_shift_i, sample_ack_i, ovr_clr_i,
    output sample_o, sample_valid_o, overrun_cnt_o, busy_o, dbg_state_o
  );

  modport master (
    output adc_dat_a_i, adc_dat_b_i, adc_valid_i, enable_i, dec_factor_i,
           avg_shift_i, sample_ack_i, ovr_clr_i,
    input  sample_o, sample_valid_o, overrun_cnt_o, busy_o, dbg_state_o
  );
endinterface

// File: rtl/adc_sample_decimator.sv
// Dual-channel ADC decimator: offset-binary to two's complement, N-sample window sum,
// arithmetic shift, 16-bit saturation and a held result with overrun counting.
module adc_sample_decimator #(
  parameter int ADC_WIDTH = 14,
  parameter int DEC_WIDTH = 16,
  parameter int ACC_WIDTH = 30,
  parameter int OUT_WIDTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  adc_sample_decimator_if.slave bus
);

  typedef enum logic {ST_IDLE = 1'b0, ST_ACCUM = 1'b1} state_t;

  state_t                        state_q, state_d;
  logic                          latch_n, clr_win;

  logic                          s1_valid_q;
  logic signed [ADC_WIDTH-1:0]   s1_a_q, s1_b_q;
  logic signed [ACC_WIDTH-1:0]   acc_a_q, acc_b_q;
  logic [DEC_WIDTH-1:0]          cnt_q, n_q, n_last;
  logic [2*OUT_WIDTH-1:0]        sample_q;
  logic                          valid_q;
  logic [15:0]                   ovr_q;

  logic                          take, last, ack_eff;
  logic signed [ACC_WIDTH-1:0]   ext_a, ext_b, sum_a, sum_b, shr_a, shr_b;
  logic [2*OUT_WIDTH-1:0]        res_word;

  function automatic logic [OUT_WIDTH-1:0] sat_out(input logic signed [ACC_WIDTH-1:0] v);
    logic signed [ACC_WIDTH-1:0] hi, lo;
    hi = ACC_WIDTH'({1'b0, {(OUT_WIDTH-1){1'b1}}});
    lo = ~hi;
    if (v > hi)      sat_out = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else if (v < lo) sat_out = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else             sat_out = v[OUT_WIDTH-1:0];
  endfunction

  // Inverted offset binary: keep the MSB, invert the rest.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else begin
      s1_valid_q <= bus.adc_valid_i;
      s1_a_q     <= {bus.adc_dat_a_i[ADC_WIDTH-1], ~bus.adc_dat_a_i[ADC_WIDTH-2:0]};
      s1_b_q     <= {bus.adc_dat_b_i[ADC_WIDTH-1], ~bus.adc_dat_b_i[ADC_WIDTH-2:0]};
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    latch_n = 1'b0;
    clr_win = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.enable_i) begin
          state_d = ST_ACCUM;
          latch_n = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (!bus.enable_i) begin
          state_d = ST_IDLE;
          clr_win = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A stage-1 sample in the disabling cycle is dropped because take needs enable_i.
  assign take    = (state_q == ST_ACCUM) && bus.enable_i && s1_valid_q;
  assign n_last  = (n_q > DEC_WIDTH'(1)) ? n_q - DEC_WIDTH'(1) : '0;
  assign last    = take && (cnt_q == n_last);

  assign ext_a   = {{(ACC_WIDTH-ADC_WIDTH){s1_a_q[ADC_WIDTH-1]}}, s1_a_q};
  assign ext_b   = {{(ACC_WIDTH-ADC_WIDTH){s1_b_q[ADC_WIDTH-1]}}, s1_b_q};
  assign sum_a   = acc_a_q + ext_a;
  assign sum_b   = acc_b_q + ext_b;
  assign shr_a   = sum_a >>> bus.avg_shift_i;
  assign shr_b   = sum_b >>> bus.avg_shift_i;
  assign res_word = {sat_out(shr_b), sat_out(shr_a)};
  assign ack_eff = bus.sample_ack_i && valid_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      acc_a_q <= '0;
      acc_b_q <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
    end else begin
      if (clr_win || last) begin
        acc_a_q <= '0;
        acc_b_q <= '0;
        cnt_q   <= '0;
      end else if (take) begin
        acc_a_q <= sum_a;
        acc_b_q <= sum_b;
        cnt_q   <= cnt_q + DEC_WIDTH'(1);
      end
      if (latch_n || last) n_q <= bus.dec_factor_i;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      sample_q <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= '0;
    end else begin
      if (last) begin
        sample_q <= res_word;
        valid_q  <= 1'b1;
      end else if (ack_eff) begin
        valid_q  <= 1'b0;
      end
      // A result overwritten without a same-cycle ack counts as lost.
      if (bus.ovr_clr_i)
        ovr_q <= '0;
      else if (last && valid_q && !bus.sample_ack_i && (ovr_q != 16'hFFFF))
        ovr_q <= ovr_q + 16'd1;
    end
  end

  assign bus.sample_o       = sample_q;
  assign bus.sample_valid_o = valid_q;
  assign bus.overrun_cnt_o  = ovr_q;
  assign bus.busy_o         = (state_q == ST_ACCUM);
  assign bus.dbg_state_o    = state_q;

endmodule

// File: tb/tb_adc_sample_decimator.sv
// Bench for adc_sample_decimator: vector table of constant windows, directed corner
// sequences and randomized windows against an arithmetic model.
module tb_adc_sample_decimator;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [31:0] exp_q[$];
  logic [13:0] wa[$];
  logic [13:0] wb[$];
  logic [31:0] last_exp;

  typedef struct {
    int          n_cfg;
    int          shift;
    int          conv_a;
    int          conv_b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  adc_sample_decimator_if u_if ();

  adc_sample_decimator u_dut (
    .ACLK    (clk),
    .ARESETN (rst_n),
    .bus     (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Converted value is 8191 - raw, so the inverse is the same arithmetic.
  function automatic logic [13:0] to_raw(input int c);
    int r;
    r = 8191 - c;
    return r[13:0];
  endfunction

  function automatic int to_conv(input logic [13:0] raw);
    return 8191 - int'(raw);
  endfunction

  function automatic logic [15:0] model_ch(input int sum, input int sh);
    int v;
    v = sum >>> sh;
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
    return v[15:0];
  endfunction

  task automatic strobe(input logic [13:0] a, input logic [13:0] b);
    u_if.adc_dat_a_i = a;
    u_if.adc_dat_b_i = b;
    u_if.adc_valid_i = 1'b1;
    tick();
    u_if.adc_valid_i = 1'b0;
  endtask

  task automatic start(input int n_cfg);
    u_if.enable_i = 1'b0;
    tick();
    tick();
    u_if.dec_factor_i = 16'(n_cfg);
    u_if.enable_i = 1'b1;
    tick();
    check("busy_on_enable", {31'd0, u_if.busy_o}, 32'd1);
  endtask

  task automatic do_ack(input string tag);
    u_if.sample_ack_i = 1'b1;
    tick();
    u_if.sample_ack_i = 1'b0;
    check({tag, "_ack_drop"}, {31'd0, u_if.sample_valid_o}, 32'd0);
  endtask

  // Feeds wa/wb as one window; shift is only correct on the final strobe.
  task automatic feed_window(input int sh, input bit scramble, input string tag);
    int n;
    logic [31:0] e;
    n = wa.size();
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) u_if.avg_shift_i = sh[3:0];
      else            u_if.avg_shift_i = 4'($urandom_range(0, 15));
      strobe(wa[i], wb[i]);
      if (scramble && i == 0) u_if.dec_factor_i = 16'($urandom_range(0, 9));
      if (i < n - 1) begin
        repeat ($urandom_range(0, 2)) tick();
        check({tag, "_early"}, {31'd0, u_if.sample_valid_o}, 32'd0);
      end
    end
    check({tag, "_lat1"}, {31'd0, u_if.sample_valid_o}, 32'd0);
    tick();
    e = exp_q.pop_front();
    check({tag, "_lat2_valid"}, {31'd0, u_if.sample_valid_o}, 32'd1);
    check({tag, "_data"}, u_if.sample_o, e);
    last_exp = e;
    wa.delete();
    wb.delete();
  endtask

  initial begin
    int ne, sa, sb, sh, ncfg;
    logic [13:0] ra, rb;
    total = 0;
    bad   = 0;
    last_exp = '0;
    rst_n = 1'b0;
    u_if.adc_dat_a_i  = '0;
    u_if.adc_dat_b_i  = '0;
    u_if.adc_valid_i  = 1'b0;
    u_if.enable_i     = 1'b0;
    u_if.dec_factor_i = '0;
    u_if.avg_shift_i  = '0;
    u_if.sample_ack_i = 1'b0;
    u_if.ovr_clr_i    = 1'b0;

    vecs[0] = '{1,  0,  8191, -8192, 32'hE000_1FFF};
    vecs[1] = '{8,  0,  8191, -8192, 32'h8000_7FFF};
    vecs[2] = '{4,  2,  100,  -100,  32'hFF9C_0064};
    vecs[3] = '{0,  0,  -5,   7,     32'h0007_FFFB};
    vecs[4] = '{2,  1,  -1,   3,     32'h0003_FFFF};
    vecs[5] = '{16, 4,  -8192, 8191, 32'h1FFF_E000};
    vecs[6] = '{3,  0,  -8192, -8192, 32'hA000_A000};
    vecs[7] = '{1,  15, 8191, -1,    32'hFFFF_0000};

    repeat (3) tick();
    check("rst_sample", u_if.sample_o, 32'd0);
    check("rst_valid", {31'd0, u_if.sample_valid_o}, 32'd0);
    check("rst_ovr", {16'd0, u_if.overrun_cnt_o}, 32'd0);
    check("rst_busy", {31'd0, u_if.busy_o}, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 8; v++) begin
      ne = (vecs[v].n_cfg < 2) ? 1 : vecs[v].n_cfg;
      for (int k = 0; k < ne; k++) begin
        wa.push_back(to_raw(vecs[v].conv_a));
        wb.push_back(to_raw(vecs[v].conv_b));
      end
      exp_q.push_back(vecs[v].exp);
      start(vecs[v].n_cfg);
      feed_window(vecs[v].shift, 1'b0, $sformatf("vec%0d", v));
      do_ack($sformatf("vec%0d", v));
    end

    // N=4, shift 2, ramp 100..400 -> 250
    start(4);
    for (int k = 1; k <= 4; k++) begin
      wa.push_back(to_raw(100 * k));
      wb.push_back(to_raw(0));
    end
    exp_q.push_back(32'h0000_00FA);
    feed_window(2, 1'b0, "ramp");
    do_ack("ramp");

    // Overrun: three back-to-back N=1 results without ack
    start(1);
    u_if.avg_shift_i = 4'd0;
    u_if.adc_dat_b_i = to_raw(0);
    u_if.adc_valid_i = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      u_if.adc_dat_a_i = to_raw(k);
      tick();
    end
    u_if.adc_valid_i = 1'b0;
    tick();
    check("ovr3_data", u_if.sample_o, 32'h0000_0003);
    check("ovr3_cnt", {16'd0, u_if.overrun_cnt_o}, 32'd2);
    check("ovr3_valid", {31'd0, u_if.sample_valid_o}, 32'd1);
    strobe(to_raw(4), to_raw(0));
    u_if.sample_ack_i = 1'b1;
    tick();
    u_if.sample_ack_i = 1'b0;
    check("ovr_ack_new_valid", {31'd0, u_if.sample_valid_o}, 32'd1);
    check("ovr_ack_new_data", u_if.sample_o, 32'h0000_0004);
    check("ovr_ack_new_cnt", {16'd0, u_if.overrun_cnt_o}, 32'd2);
    strobe(to_raw(5), to_raw(0));
    u_if.ovr_clr_i = 1'b1;
    tick();
    u_if.ovr_clr_i = 1'b0;
    check("ovr_clr_prio", {16'd0, u_if.overrun_cnt_o}, 32'd0);
    check("ovr_clr_data", u_if.sample_o, 32'h0000_0005);
    last_exp = 32'h0000_0005;
    do_ack("ovr");
    u_if.sample_ack_i = 1'b1;
    tick();
    u_if.sample_ack_i = 1'b0;
    check("idle_ack_valid", {31'd0, u_if.sample_valid_o}, 32'd0);
    check("idle_ack_cnt", {16'd0, u_if.overrun_cnt_o}, 32'd0);

    // Disable mid-window: partial sum must not leak into the next window
    start(4);
    u_if.avg_shift_i = 4'd0;
    for (int k = 0; k < 3; k++) begin
      strobe(to_raw(1000), to_raw(1000));
      tick();
    end
    strobe(to_raw(1000), to_raw(1000));
    u_if.enable_i = 1'b0;
    tick();
    tick();
    check("dis_busy", {31'd0, u_if.busy_o}, 32'd0);
    check("dis_keep_data", u_if.sample_o, last_exp);
    check("dis_keep_valid", {31'd0, u_if.sample_valid_o}, 32'd0);
    u_if.dec_factor_i = 16'd4;
    u_if.enable_i = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      wa.push_back(to_raw(10 * k));
      wb.push_back(to_raw(-1));
    end
    exp_q.push_back(32'hFFFC_0064);
    feed_window(0, 1'b0, "dis");
    do_ack("dis");

    // Reset mid-window with a pending result and nonzero overrun count
    start(1);
    u_if.avg_shift_i = 4'd0;
    strobe(to_raw(7), to_raw(0));
    tick();
    strobe(to_raw(9), to_raw(0));
    tick();
    check("pre_rst_ovr", {16'd0, u_if.overrun_cnt_o}, 32'd1);
    start(4);
    strobe(to_raw(5000), to_raw(5000));
    strobe(to_raw(5000), to_raw(5000));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_sample", u_if.sample_o, 32'd0);
    check("mid_rst_valid", {31'd0, u_if.sample_valid_o}, 32'd0);
    check("mid_rst_ovr", {16'd0, u_if.overrun_cnt_o}, 32'd0);
    check("mid_rst_busy", {31'd0, u_if.busy_o}, 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    start(4);
    for (int k = 0; k < 4; k++) begin
      wa.push_back(to_raw(1));
      wb.push_back(to_raw(2));
    end
    exp_q.push_back(32'h0008_0004);
    feed_window(0, 1'b0, "post_rst");
    do_ack("post_rst");

    // Randomized windows against the arithmetic model
    for (int w = 0; w < 24; w++) begin
      ncfg = $urandom_range(0, 7);
      ne = (ncfg < 2) ? 1 : ncfg;
      sh = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, 15);
      sa = 0;
      sb = 0;
      for (int k = 0; k < ne; k++) begin
        ra = 14'($urandom_range(0, 16383));
        rb = 14'($urandom_range(0, 16383));
        if ($urandom_range(0, 3) == 0) ra = 14'h0000;
        if ($urandom_range(0, 3) == 0) rb = 14'h3FFF;
        wa.push_back(ra);
        wb.push_back(rb);
        sa += to_conv(ra);
        sb += to_conv(rb);
      end
      exp_q.push_back({model_ch(sb, sh), model_ch(sa, sh)});
      start(ncfg);
      feed_window(sh, 1'b1, $sformatf("rnd%0d", w));
      do_ack($sformatf("rnd%0d", w));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
